// File: rtl/offchip_mem_responder_pkg.sv
// Shared definitions for the off-chip cache-line responder.
// Line width comes from `CACHE_LINE_SIZE (bytes, default 16).
// The optional OFFCHIP_MEM_ERR_EN feature uses the range-check helper below.
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif

package offchip_mem_responder_pkg;

   // Default line geometry derived from the global cache-line size
   localparam int LINE_BYTES_DEF = `CACHE_LINE_SIZE;
   localparam int LINE_W_DEF     = LINE_BYTES_DEF * 8;

   // Responder FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Operation latched at request acceptance
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // True when a line number (addr[31:4]) lies beyond the backing store
   function automatic logic line_out_of_range(input logic [27:0] line_no, input int depth);
      return ({4'b0000, line_no} >= 32'(depth));
   endfunction

endpackage

// File: rtl/offchip_line_ram.sv
// DEPTH x LINE_W single-port line store with registered read.
// Contents are never cleared; write and read share one address port.
module offchip_line_ram #(
   parameter int DEPTH  = 1024,
   parameter int LINE_W = 128
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [LINE_W-1:0]        wdata,
   output logic [LINE_W-1:0]        rdata
);

   logic [LINE_W-1:0] mem [DEPTH];
   logic [LINE_W-1:0] rdata_reg;

   // Synchronous write on we, registered read on re
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem[addr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/offchip_mem_responder.sv
// Off-chip memory responder: serves whole-line reads and write-backs from
// the memory controller with a fixed, programmable latency.
// Requests are level-held; each assertion of an enable is served once.
// Optional feature macro: OFFCHIP_MEM_ERR_EN (adds offchip_mem_err and
// flags out-of-range addresses instead of wrapping them).
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif

module offchip_mem_responder
   import offchip_mem_responder_pkg::*;
#(
   parameter int LINE_BYTES = `CACHE_LINE_SIZE,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      offchip_mem_read_en,
   input  logic                      offchip_mem_write_en,
   input  logic [31:0]               offchip_mem_addr,
   input  logic [LINE_BYTES*8-1:0]   offchip_mem_wdata,
   output logic [LINE_BYTES*8-1:0]   offchip_mem_data,
`ifdef OFFCHIP_MEM_ERR_EN
   output logic                      offchip_mem_err,
`endif
   output logic                      offchip_mem_ready
);

   localparam int LINE_W = LINE_BYTES * 8;
   localparam int IDX_W  = $clog2(DEPTH);

   // Counter preload: BUSY lasts LATENCY cycles, RESP follows
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   logic [1:0]        state_reg;
   logic [7:0]        cnt_reg;
   op_t               op_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [LINE_W-1:0] wdata_reg;
   logic              err_reg;
   logic              ready_reg;
   logic              rd_served_reg;
   logic              wr_served_reg;
   logic [LINE_W-1:0] data_hold_reg;

   logic              new_wr;
   logic              new_rd;
   logic              req_err;
   logic [IDX_W-1:0]  req_idx;
   logic              resp_rd;
   logic              resp_wr;
   logic [LINE_W-1:0] resp_data;
   logic              ram_we;
   logic              ram_re;
   logic [LINE_W-1:0] ram_rdata;

   // A request is new only until its completion has been acknowledged
   assign new_wr  = offchip_mem_write_en & ~wr_served_reg;
   assign new_rd  = offchip_mem_read_en  & ~rd_served_reg;
   assign req_idx = offchip_mem_addr[IDX_W+3:4];

`ifdef OFFCHIP_MEM_ERR_EN
   assign req_err = line_out_of_range(offchip_mem_addr[31:4], DEPTH);
   logic unused_addr_bits;
   assign unused_addr_bits = ^offchip_mem_addr[3:0];
`else
   // Without range checking, upper address bits simply wrap modulo DEPTH
   assign req_err = 1'b0;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{offchip_mem_addr[3:0], offchip_mem_addr[31:IDX_W+4]};
`endif

   // Request acceptance, latency countdown and single-cycle response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 8'd0;
         op_reg    <= OP_RD;
         idx_reg   <= '0;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         ready_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // Write wins when both enables carry a new request
               if (new_wr) begin
                  op_reg    <= OP_WR;
                  idx_reg   <= req_idx;
                  wdata_reg <= offchip_mem_wdata;
                  err_reg   <= req_err;
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= ST_BUSY;
               end else if (new_rd) begin
                  op_reg    <= OP_RD;
                  idx_reg   <= req_idx;
                  err_reg   <= req_err;
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_reg == 8'd0) begin
                  ready_reg <= 1'b1;
                  state_reg <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // ready_reg is high exactly while in RESP
   assign resp_rd = ready_reg & (op_reg == OP_RD);
   assign resp_wr = ready_reg & (op_reg == OP_WR);

   // Read is launched on the last BUSY cycle so data lands in RESP;
   // the write commits at the end of RESP unless reset aborts it
   assign ram_re = (state_reg == ST_BUSY) & (cnt_reg == 8'd0) & (op_reg == OP_RD) & ~err_reg;
   assign ram_we = resp_wr & ~err_reg & ~rst;

   offchip_line_ram #(
      .DEPTH  (DEPTH),
      .LINE_W (LINE_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (idx_reg),
      .wdata (wdata_reg),
      .rdata (ram_rdata)
   );

   // Out-of-range reads return an all-zero line
   assign resp_data = err_reg ? '0 : ram_rdata;

   // Served flags: set on completion, cleared whenever the enable is seen low
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_served_reg <= 1'b0;
         wr_served_reg <= 1'b0;
      end else begin
         if (resp_rd) begin
            rd_served_reg <= 1'b1;
         end else if (!offchip_mem_read_en) begin
            rd_served_reg <= 1'b0;
         end
         if (resp_wr) begin
            wr_served_reg <= 1'b1;
         end else if (!offchip_mem_write_en) begin
            wr_served_reg <= 1'b0;
         end
      end
   end

   // Keep the last read line so writes never disturb the data output
   always_ff @(posedge clk) begin
      if (rst) begin
         data_hold_reg <= '0;
      end else if (resp_rd) begin
         data_hold_reg <= resp_data;
      end
   end

   assign offchip_mem_data  = resp_rd ? resp_data : data_hold_reg;
   assign offchip_mem_ready = ready_reg;
`ifdef OFFCHIP_MEM_ERR_EN
   assign offchip_mem_err   = ready_reg & err_reg;
`endif

endmodule

// File: tb/tb_offchip_mem_responder.sv
// Directed scoreboard bench for offchip_mem_responder (LATENCY=4, DEPTH=1024).
// Expected responses are queued in service order and popped on each ready.
// Build with OFFCHIP_MEM_ERR_EN defined to exercise the error output.
`timescale 1ns/1ps

module tb_offchip_mem_responder;

   localparam int LINE_W  = 128;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 4;
   // Negedges from a drive at posedge+1 until ready is visible
   localparam int LAT_FULL = LATENCY + 2;

   typedef struct {
      logic [LINE_W-1:0] data;
      logic              err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              read_en;
   logic              write_en;
   logic [31:0]       addr;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] data;
   logic              ready;
   logic              err;

   int compared   = 0;
   int mismatched = 0;
   int pulses;

   exp_t              sb_q[$];
   logic [LINE_W-1:0] model_mem [int];
   logic [LINE_W-1:0] last_rd = '0;

   always #5 clk = ~clk;

   offchip_mem_responder #(
      .LINE_BYTES (16),
      .DEPTH      (DEPTH),
      .LATENCY    (LATENCY)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .offchip_mem_read_en  (read_en),
      .offchip_mem_write_en (write_en),
      .offchip_mem_addr     (addr),
      .offchip_mem_wdata    (wdata),
      .offchip_mem_data     (data),
`ifdef OFFCHIP_MEM_ERR_EN
      .offchip_mem_err      (err),
`endif
      .offchip_mem_ready    (ready)
   );

`ifndef OFFCHIP_MEM_ERR_EN
   assign err = 1'b0;
`endif

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model a read in service order and queue its expected response
   task automatic push_rd(input logic [31:0] a);
      exp_t e;
      int   line;
      line  = int'(a[31:4]);
      e.err = 1'b0;
`ifdef OFFCHIP_MEM_ERR_EN
      if (line >= DEPTH) begin
         e.err  = 1'b1;
         e.data = '0;
      end else begin
         e.data = model_mem[line];
      end
`else
      e.data = model_mem[line % DEPTH];
`endif
      last_rd = e.data;
      sb_q.push_back(e);
   endtask

   // Model a write; its response leaves the data output unchanged
   task automatic push_wr(input logic [31:0] a, input logic [LINE_W-1:0] wd);
      exp_t e;
      int   line;
      line  = int'(a[31:4]);
      e.err = 1'b0;
`ifdef OFFCHIP_MEM_ERR_EN
      if (line >= DEPTH) e.err = 1'b1;
      else model_mem[line] = wd;
`else
      model_mem[line % DEPTH] = wd;
`endif
      e.data = last_rd;
      sb_q.push_back(e);
   endtask

   task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [LINE_W-1:0] wd);
      @(posedge clk); #1;
      read_en  = rd;
      write_en = wr;
      addr     = a;
      wdata    = wd;
   endtask

   task automatic stop();
      @(posedge clk); #1;
      read_en  = 1'b0;
      write_en = 1'b0;
   endtask

   // Wait (bounded) for ready, then pop and compare one scoreboard entry
   task automatic wait_ready(input string tag, input int exp_lat);
      int   cyc;
      exp_t e;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (ready !== 1'b1 && cyc < 64);
      check({tag, "_ready"}, LINE_W'(ready), LINE_W'(1));
      if (ready === 1'b1) begin
         if (exp_lat > 0) check({tag, "_latency"}, LINE_W'(cyc), LINE_W'(exp_lat));
         check({tag, "_sb_nonempty"}, LINE_W'(sb_q.size() > 0), LINE_W'(1));
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_data"}, data, e.data);
`ifdef OFFCHIP_MEM_ERR_EN
            check({tag, "_err"}, LINE_W'(err), LINE_W'(e.err));
`endif
         end
      end
   endtask

   task automatic count_pulses(input int n, output int p);
      p = 0;
      repeat (n) begin
         @(negedge clk);
         if (ready === 1'b1) p++;
      end
   endtask

   task automatic write_line(input string tag, input logic [31:0] a, input logic [LINE_W-1:0] wd);
      push_wr(a, wd);
      start(1'b0, 1'b1, a, wd);
      wait_ready(tag, LAT_FULL);
      stop();
   endtask

   task automatic read_line(input string tag, input logic [31:0] a);
      push_rd(a);
      start(1'b1, 1'b0, a, '0);
      wait_ready(tag, LAT_FULL);
      stop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; read_en = 1'b0; write_en = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", LINE_W'(ready), LINE_W'(0));
      check("reset_data", data, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Read after reset, then hold read_en: no second pulse
      write_line("preload_10", 32'h0000_0100, {16{8'hA5}});
      push_rd(32'h0000_0100);
      start(1'b1, 1'b0, 32'h0000_0100, '0);
      wait_ready("rd_line10", LAT_FULL);
      count_pulses(10, pulses);
      check("rd_held_no_repeat", LINE_W'(pulses), LINE_W'(0));
      stop();

      // Write then read with a different low nibble
      write_line("wr_2040", 32'h0000_2040, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
      read_line("rd_204c", 32'h0000_204C);

      // Simultaneous new read and write: write first, read sees new data
      write_line("preload_30", 32'h0000_0300, 128'h0BAD_0000_0000_0000_0000_0000_0000_00D0);
      push_wr(32'h0000_0300, 128'hFEED_FACE_CAFE_BEEF_1111_2222_3333_4444);
      push_rd(32'h0000_0300);
      start(1'b1, 1'b1, 32'h0000_0300, 128'hFEED_FACE_CAFE_BEEF_1111_2222_3333_4444);
      wait_ready("both_wr_first", LAT_FULL);
      wait_ready("both_rd_second", LAT_FULL);
      stop();

      // Write-back while the served read is still held high
      write_line("preload_50x", 32'h0000_0500, 128'h5555_0000_5555_0000_5555_0000_5555_0000);
      push_rd(32'h0000_0500);
      start(1'b1, 1'b0, 32'h0000_0500, '0);
      wait_ready("wb_read", LAT_FULL);
      push_wr(32'h0000_0600, 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD);
      start(1'b1, 1'b1, 32'h0000_0600, 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD);
      wait_ready("wb_write", LAT_FULL);
      count_pulses(10, pulses);
      check("wb_no_reserve", LINE_W'(pulses), LINE_W'(0));
      stop();
      read_line("wb_reread_500", 32'h0000_0500);
      read_line("wb_read_600", 32'h0000_0600);

      // Enable dropped during BUSY: operation still completes
      push_rd(32'h0000_0100);
      start(1'b1, 1'b0, 32'h0000_0100, '0);
      @(posedge clk); #1;
      read_en = 1'b0;
      wait_ready("drop_mid_busy", LATENCY + 1);
      stop();

      // Reset in the second BUSY cycle of a write aborts it
      write_line("preload_5", 32'h0000_0050, 128'h0000_0005_0000_0005_0000_0005_0000_0005);
      start(1'b0, 1'b1, 32'h0000_0050, 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; write_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = '0;
      count_pulses(10, pulses);
      check("abort_no_ready", LINE_W'(pulses), LINE_W'(0));
      check("abort_data_reset", data, '0);
      read_line("abort_line5_old", 32'h0000_0050);

      // Address beyond DEPTH: wraps to line 0, or flags err when enabled
      write_line("preload_0", 32'h0000_0000, 128'h0F0F_0F0F_1234_5678_0F0F_0F0F_8765_4321);
      read_line("oor_read_4000", 32'h0000_4000);
      read_line("rd_line0_after", 32'h0000_0000);

      check("sb_drained", LINE_W'(sb_q.size()), LINE_W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
